// File: rtl/dac_ad56x8_sequencer.sv
// dac_ad56x8_sequencer
// Keeps an AD5628/AD5648/AD5668 octal DAC in step with a bank of channel codes.
// One channel is examined per cycle (round-robin). When a channel needs a
// write, power-down or power-up, a 32-bit frame is shifted out MSB first.
// SCLK idles high, SYNC frames each word, and DIN changes on SCLK rise.
//
// Build option: define DAC_INTERNAL_REF_EN to send the internal-reference
// enable frame (0x08000001) once after every reset, before any channel frame.
//
// Parameters:
//   NUM_CH  - number of DAC channels (1..8)
//   DATA_W  - DAC resolution: 12, 14 or 16 bits
//   CLK_DIV - SCLK half-period in CLK cycles (1..255)
//   GAP_CYC - minimum SYNC-high CLK cycles between frames (1..15)
//
// Ports:
//   CLK           - clock; all logic runs on its rising edge
//   RST           - synchronous active-high reset
//   v_dac         - channel n code in bits [n*DATA_W +: DATA_W]
//   disable_dac   - per-channel power-down request (1 = power down)
//   force_refresh - single-cycle pulse; rewrite every enabled channel
//   SCLK/SYNC/DIN - serial interface to the DAC
//   busy          - high while a frame or the inter-frame gap is in progress
//   frame_done    - single-cycle pulse as SYNC rises after a complete frame

module dac_ad56x8_sequencer #(
    parameter int NUM_CH  = 8,
    parameter int DATA_W  = 16,
    parameter int CLK_DIV = 1,
    parameter int GAP_CYC = 2
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [NUM_CH*DATA_W-1:0] v_dac,
    input  logic [NUM_CH-1:0]        disable_dac,
    input  logic                     force_refresh,
    output logic                     SCLK,
    output logic                     SYNC,
    output logic                     DIN,
    output logic                     busy,
    output logic                     frame_done
);

    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [2:0] {
        INIT,
        SCAN,
        LOAD,
        SHIFT,
        GAP
    } state_t;

    typedef enum logic [1:0] {
        WORK_WRITE,
        WORK_PDOWN,
        WORK_PUP,
        WORK_REF
    } work_t;

    state_t             state;
    work_t              work;
    logic [PTR_W-1:0]   scan_ptr;
    logic [PTR_W-1:0]   sel_ch;
    logic [DATA_W-1:0]  sel_code;
    logic [DATA_W-1:0]  shadow [NUM_CH];
    logic [NUM_CH-1:0]  valid;
    logic [NUM_CH-1:0]  pdown;
    logic [31:0]        shreg;
    logic [7:0]         div_cnt;
    logic [6:0]         half_cnt;
    logic [3:0]         gap_cnt;

    logic [DATA_W-1:0]  scan_code;
    logic [DATA_W-1:0]  scan_shadow;
    logic               scan_dis;
    logic               scan_valid;
    logic               scan_pd;
    logic               has_work;
    work_t              scan_work;
    logic [PTR_W-1:0]   next_ptr;
    logic [31:0]        frame;

    // Select the channel under the scan pointer and classify its pending work.
    // Power-state changes outrank data writes, and a disabled channel can only
    // ever produce a power-down request.
    always_comb begin
        scan_code   = '0;
        scan_shadow = '0;
        scan_dis    = 1'b0;
        scan_valid  = 1'b0;
        scan_pd     = 1'b0;
        for (int n = 0; n < NUM_CH; n++) begin
            if (scan_ptr == PTR_W'(n)) begin
                scan_code   = v_dac[n*DATA_W +: DATA_W];
                scan_shadow = shadow[n];
                scan_dis    = disable_dac[n];
                scan_valid  = valid[n];
                scan_pd     = pdown[n];
            end
        end

        has_work  = 1'b1;
        scan_work = WORK_WRITE;
        if (scan_dis && !scan_pd) begin
            scan_work = WORK_PDOWN;
        end else if (!scan_dis && scan_pd) begin
            scan_work = WORK_PUP;
        end else if (!scan_dis && (!scan_valid || scan_code != scan_shadow)) begin
            scan_work = WORK_WRITE;
        end else begin
            has_work = 1'b0;
        end

        next_ptr = (scan_ptr == PTR_W'(NUM_CH - 1)) ? '0 : scan_ptr + PTR_W'(1);
    end

    // Assemble the 32-bit word from the work captured during SCAN. Data is
    // left-justified at bit 19 so narrower parts get zero-filled low bits.
    always_comb begin
        frame = '0;
        case (work)
            WORK_WRITE: begin
                frame[27:24]        = 4'h3;
                frame[23:20]        = 4'(sel_ch);
                frame[19 -: DATA_W] = sel_code;
            end
            WORK_PDOWN: begin
                frame[27:24]  = 4'h4;
                frame[9:8]    = 2'b01;
                frame[sel_ch] = 1'b1;
            end
            WORK_PUP: begin
                frame[27:24]  = 4'h4;
                frame[9:8]    = 2'b00;
                frame[sel_ch] = 1'b1;
            end
            WORK_REF: begin
                frame[27:24] = 4'h8;
                frame[0]     = 1'b1;
            end
        endcase
    end

    // Sequencer. SHIFT counts 65 half-periods: 64 SCLK toggles followed by one
    // more half-period of SCLK high before SYNC is raised. DIN moves on each
    // SCLK rise so it is stable at the following fall, where the DAC samples.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= INIT;
            work       <= WORK_WRITE;
            scan_ptr   <= '0;
            sel_ch     <= '0;
            sel_code   <= '0;
            valid      <= '0;
            pdown      <= '0;
            for (int n = 0; n < NUM_CH; n++) begin
                shadow[n] <= '0;
            end
            shreg      <= '0;
            div_cnt    <= '0;
            half_cnt   <= '0;
            gap_cnt    <= '0;
            SCLK       <= 1'b1;
            SYNC       <= 1'b1;
            DIN        <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;

            case (state)
                INIT: begin
`ifdef DAC_INTERNAL_REF_EN
                    work  <= WORK_REF;
                    state <= LOAD;
`else
                    state <= SCAN;
`endif
                end

                SCAN: begin
                    // The pointer always advances, so after servicing a channel
                    // the next scan starts with its neighbour.
                    scan_ptr <= next_ptr;
                    if (has_work) begin
                        sel_ch   <= scan_ptr;
                        sel_code <= scan_code;
                        work     <= scan_work;
                        state    <= LOAD;
                    end
                end

                LOAD: begin
                    shreg    <= frame;
                    DIN      <= frame[31];
                    SYNC     <= 1'b0;
                    busy     <= 1'b1;
                    div_cnt  <= '0;
                    half_cnt <= '0;
                    state    <= SHIFT;
                    case (work)
                        WORK_WRITE: begin
                            shadow[sel_ch] <= sel_code;
                            valid[sel_ch]  <= 1'b1;
                        end
                        WORK_PDOWN: begin
                            pdown[sel_ch] <= 1'b1;
                        end
                        WORK_PUP: begin
                            pdown[sel_ch] <= 1'b0;
                            valid[sel_ch] <= 1'b0;
                        end
                        default: begin
                        end
                    endcase
                end

                SHIFT: begin
                    if (div_cnt == 8'(CLK_DIV - 1)) begin
                        div_cnt <= '0;
                        if (half_cnt == 7'd64) begin
                            SYNC       <= 1'b1;
                            frame_done <= 1'b1;
                            gap_cnt    <= '0;
                            state      <= GAP;
                        end else begin
                            half_cnt <= half_cnt + 7'd1;
                            SCLK     <= ~SCLK;
                            if (!SCLK) begin
                                DIN   <= shreg[30];
                                shreg <= {shreg[30:0], 1'b0};
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end

                GAP: begin
                    if (gap_cnt == 4'(GAP_CYC - 1)) begin
                        busy  <= 1'b0;
                        state <= SCAN;
                    end else begin
                        gap_cnt <= gap_cnt + 4'd1;
                    end
                end

                default: begin
                    state <= INIT;
                end
            endcase

            // Placed last so a refresh arriving in the same cycle as a LOAD
            // still wins over that channel's valid update.
            if (force_refresh) begin
                valid <= '0;
            end
        end
    end

endmodule

// File: tb/tb_dac_ad56x8_sequencer.sv
// tb_dac_ad56x8_sequencer
// Self-checking bench for dac_ad56x8_sequencer. A default 8x16 instance is
// driven from a table of directed vectors plus hand-written sequences for the
// mid-frame cases; a second 2x12 instance with CLK_DIV=3 covers narrow data
// and slow SCLK. Serial frames are reassembled from SCLK falls while SYNC is
// low and compared against frames computed by the bench.

module tb_dac_ad56x8_sequencer;

    localparam int GAP_CYC = 2;
`ifdef DAC_INTERNAL_REF_EN
    localparam bit REF_EN = 1'b1;
`else
    localparam bit REF_EN = 1'b0;
`endif
    localparam logic [31:0] REF_FRAME = 32'h0800_0001;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [127:0] v_dac;
    logic [7:0]   disable_dac;
    logic         force_refresh;
    logic         sclk, sync, din, busy, frame_done;

    logic [23:0]  v_dac12;
    logic [1:0]   disable_dac12;
    logic         force_refresh12;
    logic         sclk12, sync12, din12, busy12, frame_done12;

    dac_ad56x8_sequencer #(
        .NUM_CH(8), .DATA_W(16), .CLK_DIV(1), .GAP_CYC(GAP_CYC)
    ) dut (
        .CLK(clk), .RST(rst), .v_dac(v_dac), .disable_dac(disable_dac),
        .force_refresh(force_refresh), .SCLK(sclk), .SYNC(sync), .DIN(din),
        .busy(busy), .frame_done(frame_done)
    );

    dac_ad56x8_sequencer #(
        .NUM_CH(2), .DATA_W(12), .CLK_DIV(3), .GAP_CYC(GAP_CYC)
    ) dut12 (
        .CLK(clk), .RST(rst), .v_dac(v_dac12), .disable_dac(disable_dac12),
        .force_refresh(force_refresh12), .SCLK(sclk12), .SYNC(sync12), .DIN(din12),
        .busy(busy12), .frame_done(frame_done12)
    );

    int checks = 0;
    int errors = 0;

    // Frame capture state for the default instance
    logic [31:0] frames [$];
    logic [31:0] cap = '0;
    logic        prev_sclk = 1'b1;
    logic        prev_sync = 1'b1;
    int          bit_cnt = 0;
    int          aborted = 0;
    int          done_cnt = 0;
    int          low_len = 0;
    int          last_low_len = 0;
    int          high_len = 0;
    int          min_gap = 1000;
    bit          in_gap = 1'b0;

    // Frame capture state for the 12-bit instance
    logic [31:0] frames12 [$];
    logic [31:0] cap12 = '0;
    logic        prev_sclk12 = 1'b1;
    logic        prev_sync12 = 1'b1;
    int          bit_cnt12 = 0;
    int          low_len12 = 0;
    int          last_low_len12 = 0;
    int          period12 = 0;
    int          last_fall12 = -1;
    int          cyc = 0;

    logic [15:0] cur_code [8];
    logic [31:0] exp_q [$];
    int          done_base = 0;

    typedef struct {
        string       name;
        int          ch;
        logic [15:0] code;
        logic [7:0]  dis;
        int          nexp;
        logic [31:0] exp0;
        logic [31:0] exp1;
    } vec_t;

    vec_t vecs [8];

    always @(negedge clk) begin
        cyc++;
        if (!prev_sync && sync) begin
            if (bit_cnt == 32) begin
                frames.push_back(cap);
                in_gap = 1'b1;
            end else begin
                aborted++;
            end
            last_low_len = low_len;
            high_len = 0;
        end
        if (prev_sync && !sync) begin
            if (in_gap && high_len < min_gap) min_gap = high_len;
            in_gap  = 1'b0;
            bit_cnt = 0;
            low_len = 0;
        end
        if (sync) high_len++;
        else      low_len++;
        if (prev_sclk && !sclk && !sync) begin
            cap = {cap[30:0], din};
            bit_cnt++;
        end
        if (frame_done) done_cnt++;
        prev_sclk = sclk;
        prev_sync = sync;
    end

    always @(negedge clk) begin
        if (!prev_sync12 && sync12) begin
            if (bit_cnt12 == 32) frames12.push_back(cap12);
            last_low_len12 = low_len12;
        end
        if (prev_sync12 && !sync12) begin
            bit_cnt12   = 0;
            low_len12   = 0;
            last_fall12 = -1;
        end
        if (!sync12) low_len12++;
        if (prev_sclk12 && !sclk12 && !sync12) begin
            cap12 = {cap12[30:0], din12};
            bit_cnt12++;
            if (last_fall12 >= 0) period12 = cyc - last_fall12;
            last_fall12 = cyc;
        end
        prev_sclk12 = sclk12;
        prev_sync12 = sync12;
    end

    task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic apply_stimulus(input int ch, input logic [15:0] code, input logic [7:0] dis);
        if (ch >= 0) begin
            v_dac[ch*16 +: 16] = code;
            cur_code[ch] = code;
        end
        disable_dac = dis;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_window();
        frames.delete();
        done_base = done_cnt;
    endtask

    task automatic wait_sync_fall(input string name);
        int n;
        n = 0;
        while (sync !== 1'b0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check_output({name, "_sync_fall"}, {31'd0, sync}, 32'd0);
    endtask

    function automatic logic [31:0] write_frame(input int ch, input logic [15:0] code);
        return {4'h0, 4'h3, 4'(ch), code, 4'h0};
    endfunction

    // Expected frames for a full rewrite starting at channel first_ch
    task automatic build_rewrite(input int first_ch);
        for (int k = 0; k < 8; k++) begin
            exp_q.push_back(write_frame((first_ch + k) % 8, cur_code[(first_ch + k) % 8]));
        end
    endtask

    task automatic compare_frames(input string name);
        logic [31:0] got;
        check_output({name, "_count"}, 32'(frames.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            got = 'x;
            if (i < frames.size()) got = frames[i];
            check_output($sformatf("%s_frame%0d", name, i), got, exp_q[i]);
        end
        check_output({name, "_done_pulses"}, 32'(done_cnt - done_base), 32'(exp_q.size()));
        check_output({name, "_busy_idle"}, {31'd0, busy}, 32'd0);
        check_output({name, "_sync_idle"}, {31'd0, sync}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog timeout got running expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int rises;
        int n;
        int abort_base;
        logic psclk;

        vecs[0] = '{"ch2_write",      2,  16'h1234, 8'h00, 1, 32'h0321_2340, 32'h0};
        vecs[1] = '{"ch7_write",      7,  16'h8001, 8'h00, 1, 32'h0378_0010, 32'h0};
        vecs[2] = '{"ch5_pdown",      -1, 16'h0000, 8'h20, 1, 32'h0400_0120, 32'h0};
        vecs[3] = '{"ch5_pup",        -1, 16'h0000, 8'h00, 2, 32'h0400_0020, 32'h0350_0000};
        vecs[4] = '{"ch0_zero",       0,  16'h0000, 8'h00, 1, 32'h0300_0000, 32'h0};
        vecs[5] = '{"ch0_dis_change", 0,  16'h5555, 8'h01, 1, 32'h0400_0101, 32'h0};
        vecs[6] = '{"ch0_enable",     -1, 16'h0000, 8'h00, 2, 32'h0400_0001, 32'h0305_5550};
        vecs[7] = '{"idle_nochange",  -1, 16'h0000, 8'h00, 0, 32'h0,         32'h0};

        rst             = 1'b1;
        v_dac           = '0;
        disable_dac     = '0;
        force_refresh   = 1'b0;
        v_dac12         = {12'hABC, 12'h000};
        disable_dac12   = '0;
        force_refresh12 = 1'b0;
        for (int i = 0; i < 8; i++) cur_code[i] = 16'h0000;
        apply_stimulus(0, 16'hFFFF, 8'h00);

        wait_cycles(4);
        check_output("rst_sclk",       {31'd0, sclk},       32'd1);
        check_output("rst_sync",       {31'd0, sync},       32'd1);
        check_output("rst_din",        {31'd0, din},        32'd0);
        check_output("rst_busy",       {31'd0, busy},       32'd0);
        check_output("rst_frame_done", {31'd0, frame_done}, 32'd0);

        // Power-on rewrite of every channel
        start_window();
        rst = 1'b0;
        wait_cycles(1200);
        exp_q.delete();
        if (REF_EN) exp_q.push_back(REF_FRAME);
        build_rewrite(0);
        compare_frames("init");
        check_output("sync_low_cycles", 32'(last_low_len), 32'd65);

        exp_q.delete();
        if (REF_EN) exp_q.push_back(REF_FRAME);
        exp_q.push_back(32'h0300_0000);
        exp_q.push_back(32'h031A_BC00);
        check_output("w12_count", 32'(frames12.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            check_output($sformatf("w12_frame%0d", i), (i < frames12.size()) ? frames12[i] : 32'h0, exp_q[i]);
        end
        check_output("w12_sclk_period", 32'(period12), 32'd6);
        check_output("w12_sync_low_cycles", 32'(last_low_len12), 32'd195);

        // Directed vector table
        for (int i = 0; i < 8; i++) begin
            start_window();
            apply_stimulus(vecs[i].ch, vecs[i].code, vecs[i].dis);
            wait_cycles(300);
            exp_q.delete();
            if (vecs[i].nexp >= 1) exp_q.push_back(vecs[i].exp0);
            if (vecs[i].nexp >= 2) exp_q.push_back(vecs[i].exp1);
            compare_frames(vecs[i].name);
        end

        // Code changes while its own frame is in flight
        start_window();
        apply_stimulus(0, 16'h1111, 8'h00);
        wait_sync_fall("midframe");
        wait_cycles(20);
        apply_stimulus(0, 16'h2222, 8'h00);
        wait_cycles(400);
        exp_q.delete();
        exp_q.push_back(32'h0301_1110);
        exp_q.push_back(32'h0302_2220);
        compare_frames("midframe");

        // force_refresh pulse during SHIFT: current frame, then full rewrite
        start_window();
        apply_stimulus(1, 16'h0042, 8'h00);
        wait_sync_fall("refresh");
        wait_cycles(10);
        force_refresh = 1'b1;
        @(negedge clk);
        force_refresh = 1'b0;
        wait_cycles(1200);
        exp_q.delete();
        exp_q.push_back(32'h0310_0420);
        build_rewrite(2);
        compare_frames("refresh");

        // Reset at the 10th SCLK rise of a frame
        start_window();
        apply_stimulus(3, 16'h0F0F, 8'h00);
        wait_sync_fall("rst_mid");
        rises = 0;
        n = 0;
        psclk = sclk;
        while (rises < 10 && n < 400) begin
            @(negedge clk);
            n++;
            if (!psclk && sclk) rises++;
            psclk = sclk;
        end
        check_output("rst_mid_rise10", 32'(rises), 32'd10);
        abort_base = aborted;
        rst = 1'b1;
        @(negedge clk);
        check_output("rst_mid_sync",       {31'd0, sync},       32'd1);
        check_output("rst_mid_sclk",       {31'd0, sclk},       32'd1);
        check_output("rst_mid_frame_done", {31'd0, frame_done}, 32'd0);
        wait_cycles(2);
        rst = 1'b0;
        check_output("rst_mid_aborted", 32'(aborted - abort_base), 32'd1);
        check_output("rst_mid_no_done", 32'(done_cnt - done_base), 32'd0);
        check_output("rst_mid_no_frame", 32'(frames.size()), 32'd0);
        start_window();
        wait_cycles(1200);
        exp_q.delete();
        if (REF_EN) exp_q.push_back(REF_FRAME);
        build_rewrite(0);
        compare_frames("rst_rewrite");

        check_output("min_sync_gap_ok", {31'd0, (min_gap >= GAP_CYC)}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
